// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes shared with the calculator FSM, key lookup table, scanner state type.
// No ports. Key index is row*4+col; code 15 (CLR) doubles as the idle/reset code.
package keypad_pkg;
  localparam logic [7:0] KEY_ADD = 8'd10;
  localparam logic [7:0] KEY_SUB = 8'd11;
  localparam logic [7:0] KEY_STO = 8'd12;
  localparam logic [7:0] KEY_RCL = 8'd13;
  localparam logic [7:0] KEY_EQ  = 8'd14;
  localparam logic [7:0] KEY_CLR = 8'd15;
  localparam logic [7:0] KEY_CODE [16] = '{
    8'd1,    8'd2, 8'd3,   KEY_ADD,
    8'd4,    8'd5, 8'd6,   KEY_SUB,
    8'd7,    8'd8, 8'd9,   KEY_STO,
    KEY_RCL, 8'd0, KEY_EQ, KEY_CLR
  };
  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE} scan_state_t;
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs.
// Ports: clk, reset (async, active-high), i_d async input, o_q synchronized output (RST_VAL on reset).
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta, r_sync;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  assign o_q = r_sync;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces, and emits calculator key codes.
// Ports: clk, reset (async, active-high), row_i (rows, active-low), col_o (one-hot-zero column drive),
//        tecla (last accepted key code), ready (high while accepted key held),
//        key_strobe (only with KEYPAD_STROBE_EN: one-cycle pulse on ready rise).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [7:0] tecla,
  output logic       ready
`ifdef KEYPAD_STROBE_EN
  ,
  output logic       key_strobe
`endif
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  scan_state_t r_state, w_state_n;
  logic [DW-1:0] r_div;
  logic [CW-1:0] r_cnt, w_cnt_n, w_inc;
  logic [1:0]    r_col, w_col_n;
  logic [3:0]    r_pat, w_pat_n, w_rows;
  logic [7:0]    r_tecla, w_tecla_n;
  logic          r_ready, w_ready_n, w_sample, w_done;
  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (row_i),
    .o_q   (w_rows)
  );
  assign w_sample = r_div == DW'(SCAN_DIV - 1);
  // Entering a debounce run (from SCAN or PRESSED) restarts the count at 1.
  assign w_inc  = (r_state == SCAN || r_state == PRESSED) ? CW'(1) : r_cnt + CW'(1);
  assign w_done = w_inc == CW'(DEBOUNCE_CNT);
  always_comb begin
    w_state_n = r_state;
    w_col_n   = r_col;
    w_pat_n   = r_pat;
    w_cnt_n   = r_cnt;
    w_tecla_n = r_tecla;
    w_ready_n = r_ready;
    if (w_sample)
      case (r_state)
        SCAN, DEB_PRESS:
          if (r_state == SCAN ? $onehot(~w_rows) : w_rows == r_pat) begin
            w_pat_n   = w_rows;
            w_cnt_n   = w_inc;
            w_state_n = w_done ? PRESSED : DEB_PRESS;
            w_tecla_n = w_done ? KEY_CODE[{low_row(w_rows), r_col}] : r_tecla;
            w_ready_n = w_done;
          end else begin
            w_state_n = SCAN;
            w_col_n   = r_col + 2'd1;
          end
        PRESSED, DEB_RELEASE:
          if (&w_rows) begin
            w_cnt_n   = w_inc;
            w_state_n = w_done ? SCAN : DEB_RELEASE;
            w_col_n   = w_done ? r_col + 2'd1 : r_col;
            w_ready_n = !w_done;
          end else
            w_state_n = PRESSED;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= SCAN;
      r_div   <= '0;
      r_cnt   <= '0;
      r_col   <= '0;
      r_pat   <= '1;
      r_tecla <= KEY_CLR;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_div   <= w_sample ? '0 : r_div + DW'(1);
      r_cnt   <= w_cnt_n;
      r_col   <= w_col_n;
      r_pat   <= w_pat_n;
      r_tecla <= w_tecla_n;
      r_ready <= w_ready_n;
    end
  assign col_o = ~(4'b0001 << r_col);
  assign tecla = r_tecla;
  assign ready = r_ready;
`ifdef KEYPAD_STROBE_EN
  logic r_strobe;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_strobe <= 1'b0;
    else r_strobe <= w_ready_n & ~r_ready;
  assign key_strobe = r_strobe;
`endif
endmodule
